// File: rtl/packed_data_reader.sv
// ============================================================================
// packed_data_reader
//
// Purpose:
//   Read side of the packed-array path. Takes a DEPTH x WIDTH packed array in
//   one load beat, keeps a registered snapshot of it, and streams the entries
//   out in ascending index order, one per cycle, over a valid/ready handshake.
//   Handles consumer back-pressure, frame abort, and keeps a wrapping 8-bit
//   count of frames that completed normally.
//
// Parameters:
//   DEPTH  entries per frame (>= 2, any value)
//   WIDTH  bits per entry (>= 1)
//   IDXW   derived index width, $clog2(DEPTH); not meant to be overridden
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   load_valid   a snapshot is offered on load_data
//   load_ready   block can accept a snapshot (IDLE and out of reset)
//   load_data    packed array; entry i = load_data[i*WIDTH +: WIDTH]
//   abort        cancel the frame in progress
//   out_valid    out_data / out_index / out_last are valid
//   out_ready    consumer accepts the current entry
//   out_data     current entry
//   out_index    index of the current entry
//   out_last     current entry is the final one (index DEPTH-1)
//   busy         a frame is in progress
//   frames_done  completed-frame count, wraps 255 -> 0
//   out_parity   even parity of out_data, 0 when idle
//                (only present when READER_PARITY_EN is defined)
//
// Build option:
//   READER_PARITY_EN  adds the out_parity port and its XOR reduction.
// ============================================================================
module packed_data_reader #(
    parameter  int DEPTH = 16,
    parameter  int WIDTH = 9,
    localparam int IDXW  = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load_valid,
    output logic                   load_ready,
    input  logic [DEPTH*WIDTH-1:0] load_data,
    input  logic                   abort,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic [IDXW-1:0]        out_index,
    output logic                   out_last,
    output logic                   busy,
    output logic [7:0]             frames_done
`ifdef READER_PARITY_EN
    ,
    output logic                   out_parity
`endif
);

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(DEPTH - 1);

    state_t                       state_q;
    state_t                       state_d;
    logic [IDXW-1:0]              idx_q;
    logic [IDXW-1:0]              idx_d;
    logic [DEPTH-1:0][WIDTH-1:0]  shadow_q;
    logic [7:0]                   frames_done_q;
    logic                         ready_en_q;
    logic                         shadow_we;
    logic                         frame_done;
    logic                         at_last;
    logic                         streaming;
    logic [WIDTH-1:0]             entry_sel;

    // Current entry and end-of-frame decode, from registered state only so
    // nothing on the input side reaches the outputs combinationally.
    assign streaming = (state_q == STREAM);
    assign at_last   = (idx_q == LAST_IDX);
    assign entry_sel = shadow_q[idx_q];

    // Next-state logic. A load is taken only from IDLE; in STREAM an abort
    // wins over any transfer in the same cycle, so an aborted final entry is
    // never counted as a finished frame.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        shadow_we  = 1'b0;
        frame_done = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (load_valid && load_ready) begin
                    state_d   = STREAM;
                    idx_d     = '0;
                    shadow_we = 1'b1;
                end
            end
            STREAM: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (out_ready) begin
                    if (at_last) begin
                        state_d    = IDLE;
                        frame_done = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
        endcase
    end

    // State and index registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // load_ready must stay low through reset and rise only once the first
    // clock after deassertion has been seen; this flag provides that.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en_q <= 1'b0;
        end else begin
            ready_en_q <= 1'b1;
        end
    end

    // Snapshot register: written only when a load is accepted, so later
    // changes on load_data cannot disturb the frame being streamed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= '0;
        end else if (shadow_we) begin
            shadow_q <= load_data;
        end
    end

    // Completed-frame counter; natural 8-bit wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frames_done_q <= '0;
        end else if (frame_done) begin
            frames_done_q <= frames_done_q + 8'd1;
        end
    end

    // Outputs are forced to zero outside STREAM so idle leftovers of the
    // previous frame never appear on the bus.
    assign load_ready  = ready_en_q && (state_q == IDLE);
    assign busy        = streaming;
    assign out_valid   = streaming;
    assign out_data    = streaming ? entry_sel : '0;
    assign out_index   = streaming ? idx_q : '0;
    assign out_last    = streaming && at_last;
    assign frames_done = frames_done_q;

`ifdef READER_PARITY_EN
    // Even parity over the visible entry; zero while idle because out_data is.
    assign out_parity = ^out_data;
`endif

endmodule

// File: tb/tb_packed_data_reader.sv
// ============================================================================
// tb_packed_data_reader
//
// Self-checking bench for packed_data_reader (DEPTH=16, WIDTH=9). Every
// accepted load pushes its DEPTH expected {last, index, data} words into a
// scoreboard queue; a negedge monitor compares each valid cycle against the
// queue head and pops on transfer. Directed checks cover reset, timing,
// abort, frame counting with wrap, snapshot isolation and mid-frame reset.
// Define READER_PARITY_EN to also check out_parity.
// ============================================================================
module tb_packed_data_reader;

    localparam int DEPTH = 16;
    localparam int WIDTH = 9;
    localparam int IDXW  = 4;
    localparam int EW    = 1 + IDXW + WIDTH;

    logic                   clk;
    logic                   rst_n;
    logic                   load_valid;
    logic                   load_ready;
    logic [DEPTH*WIDTH-1:0] load_data;
    logic                   abort;
    logic                   out_valid;
    logic                   out_ready;
    logic [WIDTH-1:0]       out_data;
    logic [IDXW-1:0]        out_index;
    logic                   out_last;
    logic                   busy;
    logic [7:0]             frames_done;
`ifdef READER_PARITY_EN
    logic                   out_parity;
`endif

    logic [EW-1:0] sb[$];
    int            vectors;
    int            miscompares;
    int            fd_exp;

    packed_data_reader #(
        .DEPTH(DEPTH),
        .WIDTH(WIDTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .abort      (abort),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_index  (out_index),
        .out_last   (out_last),
        .busy       (busy),
        .frames_done(frames_done)
`ifdef READER_PARITY_EN
        ,
        .out_parity (out_parity)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check, reports any mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DEPTH*WIDTH-1:0] makeFrame(input int base, input int step);
        logic [DEPTH*WIDTH-1:0] f;
        f = '0;
        for (int i = 0; i < DEPTH; i++) begin
            f[i*WIDTH +: WIDTH] = WIDTH'(base + i * step);
        end
        return f;
    endfunction

    task automatic pushFrame(input logic [DEPTH*WIDTH-1:0] d);
        for (int i = 0; i < DEPTH; i++) begin
            sb.push_back({(i == DEPTH - 1), IDXW'(i), d[i*WIDTH +: WIDTH]});
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer a snapshot, wait (bounded) until it is taken, record expectations.
    // Returns one cycle after the accepting edge with load_valid dropped.
    task automatic applyStimulus(input logic [DEPTH*WIDTH-1:0] d);
        int n;
        n = 0;
        load_data  = d;
        load_valid = 1'b1;
        while (!load_ready && n < 100) begin
            step();
            n++;
        end
        checkOutput("load_wait", 32'(n < 100), 32'd1);
        pushFrame(d);
        step();
        load_valid = 1'b0;
        checkOutput("first_valid", 32'(out_valid), 32'd1);
    endtask

    // Drive out_ready until the frame leaves STREAM. mode 0: always ready;
    // mode 1: ready pattern 1,0,0 repeating. Returns cycles spent valid.
    task automatic streamFrame(input int mode, output int cyc);
        cyc = 0;
        while (out_valid && cyc < 200) begin
            out_ready = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
            step();
            cyc++;
        end
        out_ready = 1'b1;
        checkOutput("stream_bound", 32'(cyc < 200), 32'd1);
    endtask

    task automatic waitIndex(input int n);
        int k;
        k = 0;
        while (!(out_valid && out_index == IDXW'(n)) && k < 100) begin
            step();
            k++;
        end
        checkOutput("index_wait", 32'(k < 100), 32'd1);
    endtask

    // Scoreboard monitor, sampled on the falling edge away from updates.
    always @(negedge clk) begin
        logic [31:0] exp_word;
        if (rst_n && out_valid) begin
            exp_word = (sb.size() > 0) ? 32'(sb[0]) : 32'hFFFF_FFFF;
            checkOutput("sb_entry", 32'({out_last, out_index, out_data}), exp_word);
`ifdef READER_PARITY_EN
            checkOutput("parity", 32'(out_parity), 32'(^exp_word[WIDTH-1:0]));
`endif
            if (out_ready && sb.size() > 0) begin
                void'(sb.pop_front());
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cyc;
        int pattern_err;
        logic exp_v;
        logic [DEPTH*WIDTH-1:0] pframe;

        vectors     = 0;
        miscompares = 0;
        fd_exp      = 0;
        rst_n       = 1'b0;
        load_valid  = 1'b0;
        load_data   = '0;
        abort       = 1'b0;
        out_ready   = 1'b1;

        // Reset state.
        #2;
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_data", 32'(out_data), 32'd0);
        checkOutput("rst_out_index", 32'(out_index), 32'd0);
        checkOutput("rst_out_last", 32'(out_last), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_frames_done", 32'(frames_done), 32'd0);
        checkOutput("rst_load_ready", 32'(load_ready), 32'd0);
        step();
        step();
        rst_n = 1'b1;
        checkOutput("release_ready", 32'(load_ready), 32'd0);
        step();
        checkOutput("ready_after_release", 32'(load_ready), 32'd1);

        // Basic frame: entry i = i+1, always ready.
        applyStimulus(makeFrame(1, 1));
        checkOutput("basic_first_index", 32'(out_index), 32'd0);
        checkOutput("basic_first_data", 32'(out_data), 32'd1);
        streamFrame(0, cyc);
        fd_exp++;
        checkOutput("basic_cycles", 32'(cyc), 32'(DEPTH));
        checkOutput("basic_frames_done", 32'(frames_done), 32'(fd_exp));
        checkOutput("basic_idle_ready", 32'(load_ready), 32'd1);
        checkOutput("basic_sb_drained", 32'(sb.size()), 32'd0);

        // Back-pressure: ready 1,0,0 repeating; 16 transfers take 46 cycles.
        applyStimulus(makeFrame(1, 1));
        streamFrame(1, cyc);
        fd_exp++;
        checkOutput("bp_cycles", 32'(cyc), 32'(3 * (DEPTH - 1) + 1));
        checkOutput("bp_frames_done", 32'(frames_done), 32'(fd_exp));
        checkOutput("bp_sb_drained", 32'(sb.size()), 32'd0);

        // Abort at index 5 while ready.
        applyStimulus(makeFrame(100, 3));
        waitIndex(5);
        abort = 1'b1;
        step();
        abort = 1'b0;
        checkOutput("abort_out_valid", 32'(out_valid), 32'd0);
        checkOutput("abort_frames_done", 32'(frames_done), 32'(fd_exp));
        checkOutput("abort_load_ready", 32'(load_ready), 32'd1);
        sb.delete();

        // Restart with abort held while idle: load must still be taken.
        abort = 1'b1;
        applyStimulus(makeFrame(7, 5));
        abort = 1'b0;
        checkOutput("restart_index", 32'(out_index), 32'd0);
        streamFrame(0, cyc);
        fd_exp++;
        checkOutput("restart_frames_done", 32'(frames_done), 32'(fd_exp));

        // Parity-oriented entries (also plain data checks without parity).
        pframe = makeFrame(20, 11);
        pframe[0 +: WIDTH]     = 9'h1FF;
        pframe[WIDTH +: WIDTH] = 9'h003;
        applyStimulus(pframe);
        streamFrame(0, cyc);
        fd_exp++;
        checkOutput("parity_frames_done", 32'(frames_done), 32'(fd_exp));

        // Snapshot isolation, then reset at index 8.
        applyStimulus(makeFrame(50, 2));
        waitIndex(3);
        load_data  = makeFrame(400, 1);
        load_valid = 1'b1;
        waitIndex(8);
        rst_n      = 1'b0;
        load_valid = 1'b0;
        #1;
        checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("midrst_out_data", 32'(out_data), 32'd0);
        checkOutput("midrst_out_index", 32'(out_index), 32'd0);
        checkOutput("midrst_out_last", 32'(out_last), 32'd0);
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        checkOutput("midrst_frames_done", 32'(frames_done), 32'd0);
        checkOutput("midrst_load_ready", 32'(load_ready), 32'd0);
        sb.delete();
        fd_exp = 0;
        step();
        step();
        rst_n = 1'b1;
        checkOutput("midrst_release_ready", 32'(load_ready), 32'd0);
        step();
        checkOutput("midrst_ready_after", 32'(load_ready), 32'd1);

        // 256 back-to-back frames with load_valid held: period of 17 cycles,
        // counter wraps to 0 after the 256th frame.
        out_ready   = 1'b1;
        load_data   = makeFrame(3, 7);
        for (int f = 0; f < 256; f++) pushFrame(load_data);
        load_valid  = 1'b1;
        pattern_err = 0;
        for (int c = 0; c <= 16 + 17 * 255; c++) begin
            step();
            exp_v = ((c % 17) != 16);
            if (out_valid !== exp_v) pattern_err++;
            if (load_ready !== !exp_v) pattern_err++;
            if (c == 16) checkOutput("b2b_fd_first", 32'(frames_done), 32'd1);
            if (c == 16 + 17 * 254) checkOutput("b2b_fd_255", 32'(frames_done), 32'd255);
            if (c == 16 + 17 * 255) begin
                checkOutput("b2b_fd_wrap", 32'(frames_done), 32'd0);
                load_valid = 1'b0;
            end
        end
        checkOutput("b2b_pattern", 32'(pattern_err), 32'd0);
        checkOutput("b2b_sb_drained", 32'(sb.size()), 32'd0);
        step();
        checkOutput("b2b_stays_idle", 32'(out_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/packed_data_reader.md
# packed_data_reader

- Streams a registered snapshot of a packed two-dimensional array (DEPTH entries × WIDTH bits) out one entry per cycle over a valid/ready handshake.
- It is the read side of the packed-array path: logic that fills a `logic[DEPTH-1:0][WIDTH-1:0]` array hands it over in a single load beat, and this block serializes it to a downstream consumer.
- It supports back-pressure, abort, and a wrapping frame counter.

## Interface
- DEPTH, 16, number of entries per frame; ≥2, power of two not required.
- WIDTH, 9, bits per entry; ≥1.
- IDXW, $clog2(DEPTH), width of the index output; derived, not overridden.

- clk  input  1  rising-edge clock; the single clock of the block.
- rst_n  input  1  asynchronous, active-low reset; assertion takes effect immediately, deassertion is sampled on clk.
- load_valid  input  1  a snapshot is offered on load_data.
- load_ready  output  1  block can accept a snapshot.
- load_data  input  DEPTH*WIDTH  packed array; entry i = load_data[i*WIDTH +: WIDTH].
- abort  input  1  cancel the current frame.
- out_valid  output  1  out_data/out_index/out_last are valid.
- out_ready  input  1  consumer accepts the current entry.
- out_data  output  WIDTH  current entry.
- out_index  output  IDXW  index of the current entry.
- out_last  output  1  current entry is index DEPTH-1.
- busy  output  1  frame in progress (state STREAM).
- frames_done  output  8  count of completed frames; wraps.
- out_parity  output  1  present only with READER_PARITY_EN (see Configuration).

## Operation
- FSM has two states, IDLE and STREAM; reset state is IDLE.
- In IDLE:
  - load_ready=1 and out_valid=0.
  - On load_valid && load_ready, latch load_data into the shadow register, set idx=0, and go to STREAM.
- In STREAM:
  - load_ready=0 and out_valid=1.
  - out_data=shadow[idx], out_index=idx, out_last=(idx==DEPTH-1).
- Transfer: occurs when out_valid && out_ready.
  - Transfer with out_last=0: idx increments.
  - Transfer with out_last=1: go to IDLE; frames_done increments (255 wraps to 0).
- Abort:
  - When abort=1 in STREAM, go to IDLE at the next edge. A transfer in that cycle is not counted, and frames_done does not increment even if out_last=1.
  - Abort has priority over the transfer.
  - abort in IDLE is ignored, and a load in that cycle is still accepted.
- The shadow register is written only on load acceptance. The snapshot stays constant for the whole frame regardless of load_data changes.
- Entries are emitted in ascending index order, 0 first.
- Reset values: load_ready=0 while rst_n=0, then 1 from the first cycle after deassertion. out_valid=0, out_data=0, out_index=0, out_last=0, busy=0, frames_done=0, shadow=0, out_parity=0.
- Reset mid-frame: the frame is dropped immediately, with no partial count.

## Timing
- Load accepted at edge N → out_valid=1 in the cycle after N, showing entry 0.
- Throughput: one entry per cycle while out_ready=1. A frame takes DEPTH cycles from the first out_valid.
- Back-to-back frames:
  - Last transfer at edge K → IDLE in cycle K+1 with load_ready=1.
  - Earliest next load at edge K+1, so next out_valid comes in cycle K+2. Minimum gap is one idle cycle.
- Stall: while out_valid=1 && out_ready=0, out_data, out_index and out_last hold stable. out_valid never drops except via abort or reset.
- out_data and out_last decode combinationally from registered state and idx, with no input-to-output combinational path.
- busy equals (state==STREAM).
- frames_done updates at the same edge as the final transfer.

## Configuration
- READER_PARITY_EN defined:
  - Port out_parity exists and equals the XOR of out_data bits (even parity), valid whenever out_valid=1.
  - It is 0 when out_valid=0.
- READER_PARITY_EN undefined: the out_parity port and its logic are absent. All other behaviour is identical.

## Test plan
- Basic frame: after reset, load entry i = i+1 (DEPTH=16, WIDTH=9) with out_ready=1.
  - Expect out_data 1..16 on 16 consecutive cycles starting one cycle after load.
  - Expect out_last only on index 15 and frames_done=1.
- Back-pressure: same load, out_ready toggling 1,0,0,1,… → each entry is held stable during the 0 cycles, no entry is skipped or duplicated, and all 16 are delivered.
- Abort: abort at index 5 with out_ready=1 → out_valid=0 next cycle, frames_done unchanged, load_ready=1. A following load restarts at index 0.
- Back-to-back frames with frames_done wrap: run 256 frames with load_valid held high → exactly one idle cycle between frames, and frames_done reads 0 after frame 256.
- Snapshot and reset: change load_data mid-frame → output is unaffected. Assert rst_n=0 at index 8 → all outputs are 0 immediately, and load_ready=1 the cycle after deassertion.
- Parity (READER_PARITY_EN): entry 9'h1FF → out_parity=1; entry 9'h003 → out_parity=0.
